// File: rtl/shape_sequencer.sv
// shape_sequencer: renders border, ring and a selectable centre shape for a
// WIDTH x HEIGHT RGB565 raster. Two debounced buttons step the selection
// up/down through a 7-entry sequence (blank, 3 circles, 3 squares).
// Optional feature macro: SHAPE_SEQ_AUTO_EN (periodic auto-advance of sel).
module shape_sequencer #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int BORDER      = 7,
    parameter int SHAPE_HALF  = 8,
    parameter int RING_IN     = 10,
    parameter int RING_OUT    = 12,
    parameter int DEBOUNCE_MS = 200,
    parameter int AUTO_MS     = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1k,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [12:0] pixel_index,
    output logic [15:0] pixel_color,
    output logic [2:0]  sel
);

    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] ORANGE = 16'hFC00;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] BLACK  = 16'h0000;

    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam int CX = WIDTH / 2;
    localparam int CY = HEIGHT / 2;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         stable_q, stable_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         press_q, press_d;
    logic [2:0]         sel_q, sel_d;
    logic [15:0]        pixel_color_q, pixel_color_d;
    logic               auto_step;

    // Two-flop synchronisers for the raw button inputs.
    always_comb begin
        sync1_d = {btn_down, btn_up};
        sync2_d = sync1_q;
    end

    // Debouncer: count ticks while the input disagrees with the stable state;
    // accept after DEBOUNCE_MS ticks and emit a press on an accepted 0->1.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_1k) begin
                if (cnt_q[i] == CW'(DEBOUNCE_MS - 1)) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            press_d[i] = stable_d[i] & ~stable_q[i];
        end
    end

`ifdef SHAPE_SEQ_AUTO_EN
    localparam int AW = $clog2(AUTO_MS + 1);
    logic [AW-1:0] auto_q, auto_d;

    // Auto-advance timer; any accepted press restarts the period and wins.
    always_comb begin
        auto_d    = auto_q;
        auto_step = 1'b0;
        if (press_q != 2'b00) begin
            auto_d = '0;
        end else if (tick_1k) begin
            if (auto_q == AW'(AUTO_MS - 1)) begin
                auto_d    = '0;
                auto_step = 1'b1;
            end else begin
                auto_d = auto_q + 1'b1;
            end
        end
    end

    // Auto counter register.
    always_ff @(posedge clk) begin
        if (rst) auto_q <= '0;
        else     auto_q <= auto_d;
    end
`else
    assign auto_step = 1'b0;
`endif

    // Selection step with wrap; simultaneous up+down cancels.
    always_comb begin
        sel_d = sel_q;
        case (press_q)
            2'b01:   sel_d = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
            2'b10:   sel_d = (sel_q == 3'd0) ? 3'd6 : sel_q - 3'd1;
            2'b11:   sel_d = sel_q;
            default: if (auto_step) sel_d = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
        endcase
    end

    logic [12:0]        x_w, y_w;
    logic signed [7:0]  dx, dy;
    logic [7:0]         adx, ady;
    logic [15:0]        d2;
    logic [15:0]        shape_col;

    // Pixel colour: border > centre box > ring > background.
    always_comb begin
        x_w       = pixel_index % 13'(WIDTH);
        y_w       = pixel_index / 13'(WIDTH);
        dx        = signed'(x_w[7:0] - 8'(CX));
        dy        = signed'(y_w[7:0] - 8'(CY));
        adx       = dx[7] ? 8'(-dx) : 8'(dx);
        ady       = dy[7] ? 8'(-dy) : 8'(dy);
        d2        = 16'(adx) * 16'(adx) + 16'(ady) * 16'(ady);
        shape_col = (sel_q == 3'd1 || sel_q == 3'd4) ? GREEN :
                    (sel_q == 3'd2 || sel_q == 3'd5) ? ORANGE : RED;

        pixel_color_d = BLACK;
        if (pixel_index >= 13'(WIDTH * HEIGHT)) begin
            pixel_color_d = BLACK;
        end else if (x_w < 13'(BORDER) || x_w >= 13'(WIDTH - BORDER) ||
                     y_w < 13'(BORDER) || y_w >= 13'(HEIGHT - BORDER)) begin
            pixel_color_d = RED;
        end else if (adx <= 8'(SHAPE_HALF) && ady <= 8'(SHAPE_HALF)) begin
            if (sel_q == 3'd0)
                pixel_color_d = BLACK;
            else if (sel_q <= 3'd3)
                pixel_color_d = (d2 <= 16'(SHAPE_HALF * SHAPE_HALF)) ? shape_col : BLACK;
            else
                pixel_color_d = shape_col;
        end else if (d2 >= 16'(RING_IN * RING_IN) && d2 <= 16'(RING_OUT * RING_OUT)) begin
            pixel_color_d = (sel_q <= 3'd3) ? ORANGE : WHITE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            cnt_q         <= '0;
            press_q       <= '0;
            sel_q         <= '0;
            pixel_color_q <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
            sel_q         <= sel_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    assign pixel_color = pixel_color_q;
    assign sel         = sel_q;

endmodule

// File: doc/shape_sequencer.md
# shape_sequencer

Parametrised pixel renderer for the 96x64 RGB565 OLED path. It produces a registered colour for every `pixel_index` and shows a border, an outer ring and a centre shape. The centre shape is selected from a 7-entry sequence that is stepped up or down by two debounced buttons. It sits between the button/clock-divider logic and the OLED driver, and is the next generation of the single-button shape task: it adds bidirectional stepping, geometry parameters and an optional auto-advance mode.

## Interface
Parameters:
- `WIDTH`, 96: display width in pixels.
- `HEIGHT`, 64: display height in pixels.
- `BORDER`, 7: border thickness in pixels.
- `SHAPE_HALF`, 8: half-size of the centre shape box; circle radius equals `SHAPE_HALF`.
- `RING_IN`, 10: inner ring radius.
- `RING_OUT`, 12: outer ring radius.
- `DEBOUNCE_MS`, 200: number of `tick_1k` strobes a button must stay stable before it is accepted.
- `AUTO_MS`, 2000: auto-advance period in `tick_1k` strobes. Used only with `SHAPE_SEQ_AUTO_EN`.

Ports:
- `clk` in 1: pixel clock, 25 MHz. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `tick_1k` in 1: one-`clk`-wide strobe at 1 kHz.
- `btn_up` in 1: raw, asynchronous button input.
- `btn_down` in 1: raw, asynchronous button input.
- `pixel_index` in 13: raster index, x = index % `WIDTH`, y = index / `WIDTH`.
- `pixel_color` out 16: registered RGB565 colour.
- `sel` out 3: current selection, range 0..6.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer:
  - The debouncer holds a stable state and a tick counter.
  - While the synchronised input equals the stable state, the counter is held at 0.
  - Otherwise the counter increments on each `tick_1k`. When it reaches `DEBOUNCE_MS`, the stable state takes the input value and the counter clears.
  - A 0->1 change of the stable state produces a one-`clk` `press` pulse.
- Selection update, one `clk` after the press pulse:
  - `press_up` only: `sel` becomes (`sel`+1), wrapping 6->0.
  - `press_down` only: `sel` becomes (`sel`-1), wrapping 0->6.
  - Both pulses in the same cycle: `sel` is unchanged.
- Palette: green 16'h07E0, orange 16'hFC00, red 16'hF800, white 16'hFFFF, black 16'h0000.
- Sequence:
  - `sel`=0: centre box blank.
  - `sel` 1/2/3: green, orange, red circle.
  - `sel` 4/5/6: green, orange, red square.
- Geometry: CX = `WIDTH`/2, CY = `HEIGHT`/2. dx = x-CX and dy = y-CY are signed, 8 bits wide. Squares are computed in 16 bits.
- Pixel priority, highest first:
  1. Border: x<`BORDER`, x>=`WIDTH`-`BORDER`, y<`BORDER` or y>=`HEIGHT`-`BORDER` -> red.
  2. Centre box: |dx|<=`SHAPE_HALF` and |dy|<=`SHAPE_HALF`.
     - Circle: dx²+dy²<=`SHAPE_HALF`² -> shape colour, else black.
     - Square: the whole box takes the shape colour.
     - `sel`=0: black.
  3. Ring: `RING_IN`²<=dx²+dy²<=`RING_OUT`². Orange when `sel`<=3, white otherwise.
  4. Everything else: black.
- A `pixel_index` >= `WIDTH`*`HEIGHT` outputs black.

## Timing
- `pixel_color` has 1-cycle latency: the index presented before clk edge n produces its colour after edge n.
- Button to `sel` latency: 2 sync cycles + `DEBOUNCE_MS` ticks + 1 pulse cycle + 1 update cycle.
- A new `sel` value affects `pixel_color` from the next clock onward. There is no frame alignment.
- On reset (takes effect at the first clk edge with `rst`=1):
  - `pixel_color`=0 and `sel`=0.
  - Debounce counters = 0, stable states = 0, synchronisers = 0.
  - Auto counter = 0.
- Reset mid-debounce discards the pending press.
- A button held down produces exactly one press. Release produces none.
- A bounce shorter than `DEBOUNCE_MS` ticks restarts the count and produces no press.
- `tick_1k` asserted during `rst` is ignored.

## Configuration
- `SHAPE_SEQ_AUTO_EN` defined:
  - An auto counter increments on each `tick_1k`.
  - When it reaches `AUTO_MS`, `sel` advances by +1 with wrap and the counter clears.
  - Any accepted press clears the counter.
  - If auto-advance coincides with a press, the press wins and the auto step is dropped.
- `SHAPE_SEQ_AUTO_EN` not defined: no auto counter is built, and `sel` changes only on button presses.

## Test plan
- `rst`=1 for 2 cycles, then `rst`=0 -> `pixel_color`=0 during reset, `sel`=0; index 0 -> 16'hF800 after 1 cycle; index 3120 (48,32) -> 16'h0000.
- Hold `btn_up` for 250 ticks -> `sel`=1; index 3120 -> 16'h07E0; index 2880+58 (58,30; dist² 104) -> 16'hFC00 (ring).
- Seven `btn_up` presses from reset -> `sel` goes 1..6 then 0. At `sel`=4, index (48,32) -> 16'h07E0 and corner (56,40) -> 16'h07E0. At `sel`=4 the ring is white.
- `btn_down` from `sel`=0 -> `sel`=6. Up and down accepted in the same cycle -> `sel` unchanged.
- `btn_up` bouncing with 50-tick pulses for 1000 ticks -> no change in `sel`. `rst` asserted at debounce tick 150 -> `sel`=0 and no press afterwards.
- With `SHAPE_SEQ_AUTO_EN`, `AUTO_MS`=20 -> `sel` increments every 20 ticks. A press at tick 15 -> next auto step occurs 20 ticks after the press.
